board_initializer: RTL
======================

Name: board_initializer

Overview:
Parametrised successor to the fixed 10x10 board initializer. Writes a bordered Othello board of any even size into board memory, one cell per cycle, row-major. It supports a blank-board mode, colour swap, a memory back-pressure input, and a restartable start/busy/done handshake. It sits between the game controller FSM and the board RAM write port, muxed with the move engine.

Parameters:
BOARD_N, 8, playable side length; even, >= 4.
GRID_W, BOARD_N+2, stored side length including the 1-cell wall ring; derived, not overridden.
ADDR_W, 7, RAM address width; must satisfy 2^ADDR_W >= GRID_W*GRID_W (elaboration-time check).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request a board fill; sampled in IDLE and DONE only
mode  in  1  0 = standard opening position, 1 = blank board (walls only); latched on accepted start
swap  in  1  1 = exchange black/white in the opening four; latched on accepted start
mem_ready  in  1  RAM accepts a write this cycle
busy  out  1  high from the cycle after an accepted start until the last write is accepted
done  out  1  high in DONE state
addr  out  ADDR_W  cell address = row*GRID_W + col
data  out  2  cell code: 00 empty, 01 black, 10 white, 11 wall
wren  out  1  write request

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is synchronous and active-high.
- Reset (any state, including mid-fill): state=IDLE; busy=0, done=0, wren=0, addr=0, data=00; row/col counters=0. The partial board is abandoned.
- All outputs are registered.
- FSM states: IDLE, WRITE, DONE.
- IDLE: start=1 -> WRITE. Latch mode and swap. Next cycle: busy=1, wren=1, addr=0, data=11.
- WRITE: addr/data/wren present the current cell.
  - A write is accepted on a cycle with wren=1 and mem_ready=1.
  - On accept, advance col. On col=GRID_W-1, wrap col to 0 and increment row. Addr increments by 1.
  - mem_ready=0: addr, data and wren hold exactly; counters do not advance.
- Last cell: accepting addr=GRID_W*GRID_W-1 -> DONE. Next cycle: wren=0, busy=0, done=1. addr and data hold their last values.
- DONE: done stays 1. start=1 -> same as IDLE start (done drops, busy rises on the next cycle).
- start while in WRITE is ignored; mode and swap changes mid-fill are ignored.
- Cell classification (combinational from row/col, registered into data):
  - row==0, row==GRID_W-1, col==0 or col==GRID_W-1 -> 11.
  - Else if mode=0 and row,col in {H,H+1}, where H=BOARD_N/2:
    - row==col -> 01 (10 if swap).
    - row!=col -> 10 (01 if swap).
  - Else -> 00.
- Address is a running counter, not row*GRID_W+col arithmetic; row/col counters are width clog2(GRID_W).
- Fill duration with mem_ready held high: exactly GRID_W*GRID_W write cycles; done rises the cycle after the final accept. BOARD_N=8 gives 100 writes.

Decomposition:
- othello_pkg:
  - cell code constants CELL_EMPTY, CELL_BLACK, CELL_WHITE, CELL_WALL.
  - mode constants MODE_STANDARD, MODE_BLANK.
  - FSM state typedef.
- Sub-module `cell_classifier`: combinational. Inputs row, col, mode, swap; output 2-bit code; parameter BOARD_N. Shared later with move-validity logic for wall detection.

Test Plan:
- Default params, mode=0, swap=0, mem_ready=1, start pulse:
  - exactly 100 writes, addr 0..99.
  - addr 44 and 55 -> 01; addr 45 and 54 -> 10.
  - addrs 0-10, 19, 20, 29, 30, ..., 89-99 -> 11; all others 00.
  - done rises the cycle after addr 99.
- swap=1: addr 44/55 -> 10, 45/54 -> 01. mode=1: no 01/10 anywhere; wall pattern identical.
- Random mem_ready (about 40% low): addr/data stable while low; the accepted write sequence is identical to the first test; busy high throughout.
- BOARD_N=6, ADDR_W=6: 64 writes; addr 27/36 -> 01, 28/35 -> 10; walls at row/col 0 and 7.
- Reset asserted at addr 50 -> next cycle wren=0, busy=0, done=0, addr=0. A new start refills from addr 0.
- start pulses during WRITE and while done=1:
  - mid-fill pulse ignored; write count unchanged.
  - pulse in DONE restarts the fill and clears done the next cycle.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared Othello board encodings and the board-initializer state type.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] CELL_WALL  = 2'b11;

  localparam logic MODE_STANDARD = 1'b0;
  localparam logic MODE_BLANK    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } init_state_t;

endpackage

// File: rtl/cell_classifier.sv
// Maps a (row, col) position on the walled grid to its initial cell code.
module cell_classifier
  import othello_pkg::*;
#(
  parameter  int BOARD_N = 8,
  localparam int GRID_W  = BOARD_N + 2,
  localparam int CNT_W   = $clog2(GRID_W)
) (
  input  logic [CNT_W-1:0] row,
  input  logic [CNT_W-1:0] col,
  input  logic             mode,
  input  logic             swap,
  output logic [1:0]       code
);

  localparam int H = BOARD_N / 2;

  logic is_wall;
  logic in_centre;

  assign is_wall = (row == '0) || (row == CNT_W'(GRID_W - 1)) ||
                   (col == '0) || (col == CNT_W'(GRID_W - 1));

  assign in_centre = ((row == CNT_W'(H)) || (row == CNT_W'(H + 1))) &&
                     ((col == CNT_W'(H)) || (col == CNT_W'(H + 1)));

  // Diagonal of the opening square is black unless colours are swapped.
  always_comb begin
    code = CELL_EMPTY;
    if (is_wall) begin
      code = CELL_WALL;
    end else if ((mode != MODE_BLANK) && in_centre) begin
      code = ((row == col) ^ swap) ? CELL_BLACK : CELL_WHITE;
    end
  end

endmodule

// File: rtl/board_initializer.sv
// Fills board RAM with a walled Othello grid, one cell per accepted write, row-major.
module board_initializer
  import othello_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int ADDR_W  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              swap,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        data,
  output logic              wren
);

  localparam int GRID_W    = BOARD_N + 2;
  localparam int CNT_W     = $clog2(GRID_W);
  localparam int LAST_ADDR = GRID_W * GRID_W - 1;

  if ((BOARD_N < 4) || (BOARD_N % 2 != 0)) begin : g_chk_board
    $error("board_initializer: BOARD_N must be even and >= 4");
  end
  if ((2 ** ADDR_W) < (GRID_W * GRID_W)) begin : g_chk_addr
    $error("board_initializer: ADDR_W too narrow for GRID_W*GRID_W cells");
  end

  init_state_t      state;
  logic [CNT_W-1:0] row, col;
  logic [CNT_W-1:0] row_nxt, col_nxt;
  logic             mode_q, swap_q;
  logic             mode_sel, swap_sel;
  logic             launch, accept, row_end, last_cell;
  logic [1:0]       code_nxt;

  assign launch    = (state != ST_WRITE) && start;
  assign accept    = (state == ST_WRITE) && wren && mem_ready;
  assign row_end   = (col == CNT_W'(GRID_W - 1));
  assign last_cell = (addr == ADDR_W'(LAST_ADDR));
  assign mode_sel  = launch ? mode : mode_q;
  assign swap_sel  = launch ? swap : swap_q;

  // The classifier looks one cell ahead so data is ready in the same edge as addr.
  always_comb begin
    row_nxt = '0;
    col_nxt = '0;
    if (state == ST_WRITE) begin
      if (row_end) begin
        row_nxt = row + 1'b1;
      end else begin
        row_nxt = row;
        col_nxt = col + 1'b1;
      end
    end
  end

  cell_classifier #(.BOARD_N(BOARD_N)) u_classifier (
    .row  (row_nxt),
    .col  (col_nxt),
    .mode (mode_sel),
    .swap (swap_sel),
    .code (code_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      wren   <= 1'b0;
      addr   <= '0;
      data   <= CELL_EMPTY;
      row    <= '0;
      col    <= '0;
      mode_q <= MODE_STANDARD;
      swap_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_WRITE;
            mode_q <= mode;
            swap_q <= swap;
            busy   <= 1'b1;
            done   <= 1'b0;
            wren   <= 1'b1;
            addr   <= '0;
            row    <= '0;
            col    <= '0;
            data   <= code_nxt;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            if (last_cell) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              wren  <= 1'b0;
            end else begin
              row  <= row_nxt;
              col  <= col_nxt;
              addr <= addr + 1'b1;
              data <= code_nxt;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
